// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel arbitrated mux.
//   MUX_ARB_FIXED / MUX_ARB_RR : arbitration policy selectors for MODE
//   lock_state_t               : burst-lock state encoding
//   mux_clog2 / mux_selw       : channel-index width helpers
package mux_pkg;

  localparam int MUX_ARB_FIXED = 0;
  localparam int MUX_ARB_RR    = 1;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

  function automatic int mux_clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

  // A channel index is always at least one bit wide, even for N=1.
  function automatic int mux_selw(input int n);
    return (mux_clog2(n) < 1) ? 1 : mux_clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-base priority picker.
//   req     : per-channel request vector
//   base    : index that has highest priority; priority falls off in
//             increasing index order, wrapping from N-1 back to 0
//   gnt     : index of the winning request (0 when nothing requests)
//   any_gnt : high when at least one request is present
// base is assumed to be < N, so gnt never reaches N.
module rr_pick #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] base,
  output logic [SELW-1:0] gnt,
  output logic            any_gnt
);

  int idx;

  // Scan offsets from farthest to nearest so the nearest requester
  // (smallest offset from base) is the last one written and wins.
  always_comb begin
    gnt     = '0;
    any_gnt = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(base) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (req[idx[SELW-1:0]]) begin
        gnt     = idx[SELW-1:0];
        any_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nx.sv
// N-channel, W-bit arbitrated mux with burst locking and one registered
// output stage.
//   clk, rst_n : clock and asynchronous active-low reset
//   in_data    : channel i occupies bits [i*W +: W]
//   in_valid   : per-channel beat valid
//   in_last    : per-channel last beat of a burst
//   in_ready   : per-channel accept, at most one bit high
//   out_data   : registered data of the selected beat
//   out_valid  : output register holds a beat
//   out_last   : registered in_last of that beat
//   out_sel    : channel index the held beat came from
//   out_ready  : downstream accept
// MODE selects fixed priority (lowest index wins) or round-robin. Once a
// channel sends a non-last beat it owns the path until its last beat.
module mux_arb_nx
  import mux_pkg::*;
#(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int MODE = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N*W-1:0]                in_data,
  input  logic [N-1:0]                  in_valid,
  input  logic [N-1:0]                  in_last,
  output logic [N-1:0]                  in_ready,
  output logic [W-1:0]                  out_data,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [mux_selw(N)-1:0]        out_sel,
  input  logic                          out_ready
);

  localparam int SELW = mux_selw(N);

  lock_state_t     state_reg, state_next;
  logic [SELW-1:0] lock_ch_reg, lock_ch_next;
  logic [SELW-1:0] base;
  logic [SELW-1:0] pick_gnt;
  logic            pick_any;
  logic [SELW-1:0] gnt;
  logic [W-1:0]    sel_data;
  logic            sel_last;
  logic            sel_valid;
  logic            load_en;
  logic            accept;

  // Round-robin keeps a rotating pointer; fixed priority always scans
  // from channel 0.
  generate
    if (MODE == MUX_ARB_RR) begin : g_rr
      logic [SELW-1:0] ptr_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr_reg <= '0;
        end else if (accept && sel_last) begin
          ptr_reg <= (gnt == SELW'(N - 1)) ? '0 : gnt + SELW'(1);
        end
      end

      assign base = ptr_reg;
    end else begin : g_fixed
      assign base = '0;
    end
  endgenerate

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .req     (in_valid),
    .base    (base),
    .gnt     (pick_gnt),
    .any_gnt (pick_any)
  );

  // While locked, only the owning channel is a candidate, even when it
  // has no beat ready: other channels must not fill the gap.
  assign gnt = (state_reg == ST_LOCKED) ? lock_ch_reg : pick_gnt;

  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SELW'(i)) begin
        sel_data  = in_data[i*W +: W];
        sel_last  = in_last[i];
        sel_valid = in_valid[i];
      end
    end
  end

  assign load_en = ~out_valid | out_ready;
  assign accept  = rst_n & load_en & sel_valid;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = accept & (gnt == SELW'(gi));
    end
  endgenerate

  // Output stage: a load takes precedence over draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_sel   <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Burst-lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_UNLOCKED;
      lock_ch_reg <= '0;
    end else begin
      state_reg   <= state_next;
      lock_ch_reg <= lock_ch_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    lock_ch_next = lock_ch_reg;
    if (accept) begin
      case (state_reg)
        ST_UNLOCKED: begin
          if (!sel_last) begin
            state_next   = ST_LOCKED;
            lock_ch_next = gnt;
          end
        end
        ST_LOCKED: begin
          if (sel_last) begin
            state_next = ST_UNLOCKED;
          end
        end
        default: state_next = ST_UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arb_nx.sv
// Randomised scoreboard bench for mux_arb_nx. Three instances share one
// stimulus stream: N=4/W=32 round-robin, N=4/W=32 fixed priority and
// N=3/W=8 round-robin. A reference model per instance predicts in_ready
// and pushes each accepted beat into a queue; a separate monitor compares
// the held output beat against the queue front every cycle.
module tb_mux_arb_nx;

  typedef struct {
    int          sel;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  vld = '0;
  logic [3:0]  lst = '0;
  logic [31:0] dat [4];

  logic [127:0] data4;
  logic [23:0]  data3;
  assign data4 = {dat[3], dat[2], dat[1], dat[0]};
  assign data3 = {dat[2][7:0], dat[1][7:0], dat[0][7:0]};

  logic [3:0]  rdy0, rdy1;
  logic [2:0]  rdy2;
  logic [31:0] od0, od1;
  logic [7:0]  od2;
  logic        ov0, ov1, ov2, ol0, ol1, ol2;
  logic [1:0]  os0, os1, os2;

  logic [3:0]  dut_rdy [3];
  logic [31:0] dut_od  [3];
  logic        dut_ov  [3];
  logic        dut_ol  [3];
  logic [1:0]  dut_os  [3];

  assign dut_rdy[0] = rdy0;
  assign dut_rdy[1] = rdy1;
  assign dut_rdy[2] = {1'b0, rdy2};
  assign dut_od[0]  = od0;
  assign dut_od[1]  = od1;
  assign dut_od[2]  = {24'h0, od2};
  assign dut_ov[0]  = ov0;
  assign dut_ov[1]  = ov1;
  assign dut_ov[2]  = ov2;
  assign dut_ol[0]  = ol0;
  assign dut_ol[1]  = ol1;
  assign dut_ol[2]  = ol2;
  assign dut_os[0]  = os0;
  assign dut_os[1]  = os1;
  assign dut_os[2]  = os2;

  mux_arb_nx #(.W(32), .N(4), .MODE(1)) u_rr4 (
    .clk (clk), .rst_n (rst_n), .in_data (data4), .in_valid (vld),
    .in_last (lst), .in_ready (rdy0), .out_data (od0), .out_valid (ov0),
    .out_last (ol0), .out_sel (os0), .out_ready (out_ready)
  );

  mux_arb_nx #(.W(32), .N(4), .MODE(0)) u_fix4 (
    .clk (clk), .rst_n (rst_n), .in_data (data4), .in_valid (vld),
    .in_last (lst), .in_ready (rdy1), .out_data (od1), .out_valid (ov1),
    .out_last (ol1), .out_sel (os1), .out_ready (out_ready)
  );

  mux_arb_nx #(.W(8), .N(3), .MODE(1)) u_rr3 (
    .clk (clk), .rst_n (rst_n), .in_data (data3), .in_valid (vld[2:0]),
    .in_last (lst[2:0]), .in_ready (rdy2), .out_data (od2), .out_valid (ov2),
    .out_last (ol2), .out_sel (os2), .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Reference model: per-instance configuration and state.
  int    m_n    [3] = '{4, 4, 3};
  int    m_mode [3] = '{1, 0, 1};
  int    m_wmask_bits [3] = '{32, 32, 8};
  int    m_ptr  [3];
  bit    m_full [3];
  bit    m_lock [3];
  int    m_lch  [3];
  beat_t q0 [$];
  beat_t q1 [$];
  beat_t q2 [$];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ptr[k]  = 0;
      m_full[k] = 1'b0;
      m_lock[k] = 1'b0;
      m_lch[k]  = 0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic q_push(input int k, input beat_t b);
    case (k)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  // Evaluate one cycle of instance k from the inputs currently driven.
  task automatic model_eval(input int k);
    int          n, g, base;
    bit          cand, load_en;
    logic [3:0]  exp_rdy;
    beat_t       b;
    logic [31:0] mask;
    n    = m_n[k];
    mask = (m_wmask_bits[k] == 32) ? 32'hFFFF_FFFF : ((32'h1 << m_wmask_bits[k]) - 32'h1);
    chk("out_valid", k, {31'h0, dut_ov[k]}, {31'h0, m_full[k]});
    load_en = !m_full[k] || out_ready;
    g    = 0;
    cand = 1'b0;
    if (m_lock[k]) begin
      g    = m_lch[k];
      cand = vld[g];
    end else begin
      base = (m_mode[k] == 1) ? m_ptr[k] : 0;
      for (int off = 0; off < n; off++) begin
        if (!cand && vld[(base + off) % n]) begin
          g    = (base + off) % n;
          cand = 1'b1;
        end
      end
    end
    exp_rdy = '0;
    if (load_en && cand) exp_rdy[g] = 1'b1;
    chk("in_ready", k, {28'h0, dut_rdy[k]}, {28'h0, exp_rdy});
    if (load_en && cand) begin
      b.sel  = g;
      b.data = dat[g] & mask;
      b.last = lst[g];
      q_push(k, b);
      m_full[k] = 1'b1;
      if (!lst[g]) begin
        m_lock[k] = 1'b1;
        m_lch[k]  = g;
      end else begin
        m_lock[k] = 1'b0;
        if (m_mode[k] == 1) m_ptr[k] = (g + 1) % n;
      end
    end else if (out_ready) begin
      m_full[k] = 1'b0;
    end
  endtask

  // Drive one cycle of random stimulus (called at a falling edge),
  // evaluate the model, then advance to the next falling edge.
  task automatic step(input int pv, input int pl, input int pr);
    for (int i = 0; i < 4; i++) begin
      vld[i] = (int'($urandom_range(99)) < pv);
      lst[i] = (int'($urandom_range(99)) < pl);
      dat[i] = $urandom;
    end
    out_ready = (int'($urandom_range(99)) < pr);
    #1;
    for (int k = 0; k < 3; k++) model_eval(k);
    @(negedge clk);
  endtask

  task automatic reset_checks();
    for (int k = 0; k < 3; k++) begin
      chk("reset_in_ready", k, {28'h0, dut_rdy[k]}, 32'h0);
      chk("reset_out_valid", k, {31'h0, dut_ov[k]}, 32'h0);
      chk("reset_out_sel", k, {30'h0, dut_os[k]}, 32'h0);
    end
  endtask

  // Monitor: compare the held beat against the scoreboard each cycle and
  // retire it when the downstream accepts.
  initial begin
    beat_t b;
    bit    have;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        if (dut_ov[k]) begin
          have = 1'b0;
          case (k)
            0: if (q0.size() > 0) begin b = q0[0]; have = 1'b1; end
            1: if (q1.size() > 0) begin b = q1[0]; have = 1'b1; end
            default: if (q2.size() > 0) begin b = q2[0]; have = 1'b1; end
          endcase
          if (!have) begin
            chk("unexpected_beat", k, 32'h1, 32'h0);
          end else begin
            chk("out_sel", k, {30'h0, dut_os[k]}, b.sel);
            chk("out_data", k, dut_od[k], b.data);
            chk("out_last", k, {31'h0, dut_ol[k]}, {31'h0, b.last});
            $display("beat dut%0d t=%0t sel=%0d data=%0h last=%0b ready=%0b",
                     k, $time, dut_os[k], dut_od[k], dut_ol[k], out_ready);
            if (out_ready) begin
              case (k)
                0: void'(q0.pop_front());
                1: void'(q1.pop_front());
                default: void'(q2.pop_front());
              endcase
            end
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) dat[i] = 32'h0;
    model_reset();
    rst_n     = 1'b0;
    vld       = 4'hF;
    lst       = 4'hF;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;

    // All channels valid, single beats, no backpressure: rotation / priority.
    repeat (24) step(100, 100, 100);
    // Full backpressure followed by release.
    repeat (5) step(100, 100, 0);
    repeat (5) step(100, 100, 100);
    // Mixed bursts with random valid and backpressure.
    repeat (300) step(70, 50, 50);
    repeat (300) step(60, 25, 80);
    // Long bursts, then reset in the middle of them.
    repeat (40) step(80, 10, 70);
    rst_n = 1'b0;
    vld   = 4'hF;
    #1;
    reset_checks();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) step(80, 20, 70);
    repeat (20) step(100, 0, 100);
    repeat (50) step(50, 50, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
